alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Parametrised, multi-cycle successor to the integer-pipeline ALU. It executes the base RV integer operations plus the RV M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) on XLEN-bit operands. A valid/ready handshake on input and output lets the execute stage stall while an iterative multiply or divide runs. A flush input lets the hazard unit abort an in-flight operation.

## Interface
- XLEN, 32, operand/result width; power of two, ≥ 8.
- SHW, $clog2(XLEN), shift-amount width (derived; do not override).
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- flush_i  input  1  abort current operation; highest priority after reset.
- in_valid_i  input  1  operands/operation valid.
- in_ready_o  output  1  unit can accept; high only in IDLE.
- alu_op1_i  input  XLEN  operand A (rs1).
- alu_op2_i  input  XLEN  operand B (rs2/imm).
- alu_operation_i  input  5  bit4 = M-extension select; bits[3:0] = operation.
- out_valid_o  output  1  result valid; held until accepted.
- out_ready_i  input  1  consumer accepts result.
- alu_result_o  output  XLEN  registered result.
- zero_flag_o  output  1  registered; 1 when alu_result_o == 0.

## Operation
- Base ops (bit4=0): 0000 ADD, 1000 SUB, 0001 SLL, 0101 SRL, 1101 SRA, 0010 SLT (signed), 0011 SLTU, 0100 XOR, 0110 OR, 0111 AND, 1111 all-ones (debug), others → 0. Shifts use alu_op2_i[SHW-1:0] only. Arithmetic wraps modulo 2^XLEN.
- M ops (bit4=1, bits[2:0]; bit3 ignored): 000 MUL (low XLEN of product), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Multiply: radix-2 shift-add on magnitudes, XLEN iterations, 2·XLEN accumulator. Sign correction is a two's-complement negate of the full product when exactly one signed operand is negative.
- Divide: restoring, XLEN iterations on magnitudes. Quotient is negated when the signed operand signs differ. Remainder takes the sign of the dividend. Truncation toward zero.
- Special cases, resolved at accept with no iteration:
  - divisor 0: DIV/DIVU → all-ones; REM/REMU → dividend.
  - DIV of the most-negative value by −1 → dividend; REM of the same → 0.
- FSM states IDLE, MUL, DIV, DONE:
  - IDLE: on in_valid_i, capture operands. Go to DONE for base ops and special cases, to MUL for multiplies, to DIV for other divides.
  - MUL/DIV: iteration counter counts XLEN−1 down to 0. At 0, write the result and go to DONE.
  - DONE: out_valid_o=1. When out_ready_i=1, go to IDLE.
- flush_i in any state → IDLE next cycle, out_valid_o=0, no result written. A request presented in the same cycle as flush_i is not accepted.
- Inputs are sampled only at accept; later changes to them have no effect.

## Timing
- Reset values: state IDLE, in_ready_o=1, out_valid_o=0, alu_result_o=0, zero_flag_o=0 (set with result only), counter 0.
- Base op and special case: accept at cycle T, out_valid_o at T+1.
- MUL*/DIV*/REM*: accept at T, out_valid_o at T+1+XLEN (T+33 for XLEN=32).
- Throughput: with out_ready_i tied high, a new accept occurs every 2 cycles for base ops, since in_ready_o returns at T+2.
- Backpressure: alu_result_o and zero_flag_o stay stable while out_valid_o=1 and out_ready_i=0.
- Reset mid-iteration: counter and accumulators are discarded, same as flush.

## Test plan
- Base ops: ADD 0x7FFFFFFF+1 → 0x80000000. SUB 5−5 → 0 with zero_flag_o=1. SRA 0x80000000 by 35 → 0xF0000000 (only low 5 bits used). SLT −1<1 → 1; SLTU → 0. Result appears 1 cycle after accept.
- Multiply: MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001. MULH → 0x00000000. MULHU → 0xFFFFFFFE. MULHSU(−1, 2) → 0xFFFFFFFF. Each out_valid_o exactly 33 cycles after accept.
- Divide: DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 7/2 → 3. REMU 7/2 → 1. Latency 33.
- Special cases: DIVU x/0 → 0xFFFFFFFF and REM 9/0 → 9, both in 1 cycle. DIV 0x80000000/−1 → 0x80000000; REM of same → 0.
- Handshake: hold out_ready_i=0 for 10 cycles after DONE → result stable, in_ready_o=0. Then assert out_ready_i → in_ready_o=1 next cycle.
- Flush/reset: assert flush_i 10 cycles into a DIV → IDLE next cycle, out_valid_o never asserts. Repeat with rst_i → all outputs at reset values. A following ADD completes normally.
- Parametrisation: rerun the base and M tests with XLEN=16 (e.g. MULHU 0xFFFF×0xFFFF → 0xFFFE, latency 17).

Source files
------------

// File: rtl/alu_muldiv.sv
// alu_muldiv: multi-cycle integer ALU with the M-extension operations.
// Base ops finish one cycle after accept. Multiplies use radix-2 shift-add and
// divides use restoring division, each running XLEN iterations on magnitudes.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i (abort in-flight work)
//   in_valid_i / in_ready_o       : operand handshake (ready only in IDLE)
//   alu_op1_i, alu_op2_i          : operands A and B
//   alu_operation_i               : bit4 = M select, bits[3:0] = operation
//   out_valid_o / out_ready_i     : result handshake (held until accepted)
//   alu_result_o, zero_flag_o     : registered result and result==0 flag
module alu_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] alu_op1_i,
  input  logic [XLEN-1:0] alu_op2_i,
  input  logic [4:0]      alu_operation_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] alu_result_o,
  output logic            zero_flag_o
);
  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, mag_b_q, mag_b_d;
  logic              neg_q, neg_d;
  logic [1:0]        sel_q, sel_d;
  logic [XLEN-1:0]   res_d;
  logic              wr;

  // Base-operation result, computed straight from the inputs at accept
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res;
  always_comb begin
    base_res = '0;
    shamt    = alu_op2_i[SHW-1:0];
    case (alu_operation_i[3:0])
      4'b0000: base_res = alu_op1_i + alu_op2_i;
      4'b1000: base_res = alu_op1_i - alu_op2_i;
      4'b0001: base_res = alu_op1_i << shamt;
      4'b0101: base_res = alu_op1_i >> shamt;
      4'b1101: base_res = XLEN'($signed(alu_op1_i) >>> shamt);
      4'b0010: base_res = XLEN'($signed(alu_op1_i) < $signed(alu_op2_i));
      4'b0011: base_res = XLEN'(alu_op1_i < alu_op2_i);
      4'b0100: base_res = alu_op1_i ^ alu_op2_i;
      4'b0110: base_res = alu_op1_i | alu_op2_i;
      4'b0111: base_res = alu_op1_i & alu_op2_i;
      4'b1111: base_res = '1;
      default: base_res = '0;
    endcase
  end

  // M-op decode: operand signedness, magnitudes, result sign, special cases
  logic [2:0]      mop;
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg, neg_acc, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_res;
  always_comb begin
    mop      = alu_operation_i[2:0];
    is_div   = mop[2];
    a_sgn    = is_div ? ~mop[0] : (mop[1:0] != 2'b11);
    b_sgn    = is_div ? ~mop[0] : ~mop[1];
    a_neg    = a_sgn & alu_op1_i[XLEN-1];
    b_neg    = b_sgn & alu_op2_i[XLEN-1];
    mag_a    = a_neg ? -alu_op1_i : alu_op1_i;
    mag_b    = b_neg ? -alu_op2_i : alu_op2_i;
    // Remainder follows the dividend; quotient and products follow sign parity
    neg_acc  = (is_div & mop[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = (alu_op2_i == '0);
    div_ovf  = ~mop[0] & (alu_op1_i == MIN_NEG) & (alu_op2_i == '1);
    if (div_zero) special_res = mop[1] ? alu_op1_i : '1;
    else          special_res = mop[1] ? '0 : alu_op1_i;
  end

  // One iteration step for each engine; hi/lo are shared between them
  logic [XLEN:0] mul_sum, div_shift, div_diff;
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_b_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag_b_q};
  end

  // Next-state and datapath update
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   div_sel;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    sel_d   = sel_q;
    res_d   = '0;
    wr      = 1'b0;
    prod    = '0;
    div_sel = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          if (!alu_operation_i[4]) begin
            res_d   = base_res;
            wr      = 1'b1;
            state_d = S_DONE;
          end else if (is_div && (div_zero || div_ovf)) begin
            res_d   = special_res;
            wr      = 1'b1;
            state_d = S_DONE;
          end else begin
            sel_d   = mop[1:0];
            neg_d   = neg_acc;
            mag_b_d = mag_b;
            hi_d    = '0;
            lo_d    = mag_a;
            cnt_d   = SHW'(XLEN - 1);
            state_d = is_div ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL: begin
        hi_d  = mul_sum[XLEN:1];
        lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          prod    = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
          res_d   = (sel_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          wr      = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        if (!div_diff[XLEN]) begin
          hi_d = div_diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = div_shift[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          div_sel = sel_q[1] ? hi_d : lo_d;
          res_d   = neg_q ? -div_sel : div_sel;
          wr      = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        if (out_ready_i) state_d = S_IDLE;
      end
    endcase
    // Flush drops any request or in-flight work without touching the result
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      wr      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      mag_b_q      <= '0;
      neg_q        <= 1'b0;
      sel_q        <= '0;
      in_ready_o   <= 1'b1;
      out_valid_o  <= 1'b0;
      alu_result_o <= '0;
      zero_flag_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mag_b_q     <= mag_b_d;
      neg_q       <= neg_d;
      sel_q       <= sel_d;
      in_ready_o  <= (state_d == S_IDLE);
      out_valid_o <= (state_d == S_DONE);
      if (wr) begin
        alu_result_o <= res_d;
        zero_flag_o  <= (res_d == '0);
      end
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed plan items, handshake,
// flush/reset, randomized ops against an arithmetic reference model, and an
// XLEN=16 instance for parametrisation.
module tb_alu_muldiv;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready, in_ready, out_valid, zero;
  logic [31:0] op1, op2, res;
  logic [4:0]  opc;

  logic        in_valid16, in_ready16, out_valid16, zero16;
  logic [15:0] a16, b16, res16;
  logic [4:0]  opc16;

  int checks = 0;
  int errors = 0;

  alu_muldiv #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .alu_op1_i(op1), .alu_op2_i(op2),
    .alu_operation_i(opc), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .alu_result_o(res), .zero_flag_o(zero)
  );

  alu_muldiv #(.XLEN(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .in_valid_i(in_valid16),
    .in_ready_o(in_ready16), .alu_op1_i(a16), .alu_op2_i(b16),
    .alu_operation_i(opc16), .out_valid_o(out_valid16), .out_ready_i(1'b1),
    .alu_result_o(res16), .zero_flag_o(zero16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result from plain 64-bit / signed integer arithmetic
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    logic [63:0] p;
    logic        ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (!op[4]) begin
      case (op[3:0])
        4'b0000: return a + b;
        4'b1000: return a - b;
        4'b0001: return a << b[4:0];
        4'b0101: return a >> b[4:0];
        4'b1101: return 32'(sa >>> b[4:0]);
        4'b0010: return (sa < sb) ? 32'd1 : 32'd0;
        4'b0011: return (a < b) ? 32'd1 : 32'd0;
        4'b0100: return a ^ b;
        4'b0110: return a | b;
        4'b0111: return a & b;
        4'b1111: return 32'hFFFF_FFFF;
        default: return 32'd0;
      endcase
    end
    case (op[2:0])
      3'b000: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
      3'b001: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'b010: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[4]) return 1;
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op with out_ready high; check latency, result, flag and return to idle
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int          lat;
    exp = ref_result(op, a, b);
    @(negedge clk);
    chk({tag, "_rdy"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1; op1 = a; op2 = b; opc = op; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op1 = $urandom; op2 = $urandom; opc = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(ref_latency(op, a, b)));
    chk({tag, "_res"}, 64'(res), 64'(exp));
    chk({tag, "_zero"}, 64'(zero), 64'(exp == 32'd0));
    @(posedge clk); #1;
    chk({tag, "_idle"}, {62'd0, in_ready, out_valid}, 64'b10);
  endtask

  task automatic run16(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp, input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    in_valid16 = 1'b1; opc16 = op; a16 = a; b16 = b;
    @(posedge clk); #1;
    in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 1;
    while (!out_valid16 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, 64'(res16), 64'(exp));
    chk({tag, "_zero"}, 64'(zero16), 64'(exp == 16'd0));
    @(posedge clk); #1;
  endtask

  initial begin
    bit seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op1 = '0; op2 = '0; opc = '0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; opc16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {60'd0, in_ready, out_valid, zero, 1'b0}, 64'b1000);
    chk("reset_res", 64'(res), 64'd0);
    @(negedge clk); rst = 1'b0;

    // Directed base, multiply, divide and special cases
    run_op(5'b00000, 32'h7FFF_FFFF, 32'd1, "add_ovf");
    run_op(5'b01000, 32'd5, 32'd5, "sub_zero");
    run_op(5'b01101, 32'h8000_0000, 32'd35, "sra35");
    run_op(5'b00010, 32'hFFFF_FFFF, 32'd1, "slt");
    run_op(5'b00011, 32'hFFFF_FFFF, 32'd1, "sltu");
    run_op(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul");
    run_op(5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh");
    run_op(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    run_op(5'b10010, 32'hFFFF_FFFF, 32'd2, "mulhsu");
    run_op(5'b10100, 32'hFFFF_FFF9, 32'd2, "div");
    run_op(5'b10110, 32'hFFFF_FFF9, 32'd2, "rem");
    run_op(5'b10101, 32'd7, 32'd2, "divu");
    run_op(5'b10111, 32'd7, 32'd2, "remu");
    run_op(5'b10101, 32'h1234_5678, 32'd0, "divu0");
    run_op(5'b10110, 32'd9, 32'd0, "rem0");
    run_op(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

    // Backpressure: result held while out_ready is low
    @(negedge clk);
    in_valid = 1'b1; opc = 5'b00100; op1 = 32'h0000_0F0F; op2 = 32'h0000_FF00; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; op1 = $urandom;
    chk("bp_valid", 64'(out_valid), 64'(1));
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_hold", {30'd0, in_ready, out_valid, res}, {30'd0, 2'b01, 32'h0000_F00F});
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {62'd0, in_ready, out_valid}, 64'b10);

    // Flush 10 cycles into a divide
    @(negedge clk);
    in_valid = 1'b1; opc = 5'b10100; op1 = 32'd100; op2 = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("fl_busy", 64'(in_ready), 64'(0));
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_idle", {62'd0, in_ready, out_valid}, 64'b10);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("fl_novalid", 64'(seen), 64'(0));
    chk("fl_result_kept", 64'(res), 64'h0000_F00F);

    // Request together with flush is dropped
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; opc = 5'b00000; op1 = 32'd1; op2 = 32'd2;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_req_drop", {62'd0, in_ready, out_valid}, 64'b10);

    // Reset mid-divide
    @(negedge clk);
    in_valid = 1'b1; opc = 5'b10101; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid", {28'd0, in_ready, out_valid, zero, 1'b0, res}, {28'd0, 4'b1000, 32'd0});
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst_novalid", 64'(seen), 64'(0));
    run_op(5'b00000, 32'd2, 32'd3, "add_after_rst");

    // Randomized ops vs reference model
    for (int i = 0; i < 60; i++) begin
      run_op(5'($urandom), pick(), pick(), $sformatf("rnd%0d", i));
    end

    // XLEN=16 instance
    run16(5'b00000, 16'h7FFF, 16'h0001, 16'h8000, 1, "x16_add");
    run16(5'b10011, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17, "x16_mulhu");
    run16(5'b10000, 16'hFFFF, 16'hFFFF, 16'h0001, 17, "x16_mul");
    run16(5'b10100, 16'hFFF9, 16'h0002, 16'hFFFD, 17, "x16_div");
    run16(5'b10110, 16'hFFF9, 16'h0002, 16'hFFFF, 17, "x16_rem");
    run16(5'b10101, 16'h0007, 16'h0000, 16'hFFFF, 1, "x16_divu0");
    run16(5'b11001, 16'h1234, 16'h5678, 16'h0626, 17, "x16_mulh");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
